// File: rtl/comp_pkg.sv
// Shared types, constants and helpers for the pipelined magnitude comparator.
package comp_pkg;

    // One-hot comparison outcome, bit order {gt, lt, eq}.
    typedef logic [2:0] cmp_res_t;

    localparam cmp_res_t CMP_GT = 3'b100;
    localparam cmp_res_t CMP_LT = 3'b010;
    localparam cmp_res_t CMP_EQ = 3'b001;

    // Output-register occupancy states. While FULL, the result registers hold a live result.
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    // Wide carrier type for the counter helper. Counters can be up to 64 bits wide.
    typedef logic [63:0] cnt_wide_t;

    // Saturating increment: the counter sticks at max and never wraps.
    function automatic cnt_wide_t sat_inc(input cnt_wide_t cnt, input cnt_wide_t max);
        return (cnt >= max) ? cnt : cnt + 64'd1;
    endfunction

endpackage

// File: rtl/mag_comp_core.sv
// Combinational magnitude comparator with unsigned or two's-complement interpretation.
module mag_comp_core
    import comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output cmp_res_t         res,
    output logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] min
);

    // Extending by one bit, with the MSB replicated only in signed mode, lets a single
    // signed compare cover both interpretations. With WIDTH=1 a set bit then reads as -1.
    logic signed [WIDTH:0] ext_a;
    logic signed [WIDTH:0] ext_b;

    assign ext_a = {signed_mode & a[WIDTH-1], a};
    assign ext_b = {signed_mode & b[WIDTH-1], b};

    // Select the outcome, then steer the operands. On equality a is reported as max and b as min.
    always_comb begin
        // NOTE: every output gets a default first, so no path can leave it unassigned and infer a latch.
        res = CMP_EQ;
        max = a;
        min = b;
        if (ext_a > ext_b) begin
            res = CMP_GT;
        end else if (ext_a < ext_b) begin
            res = CMP_LT;
            max = b;
            min = a;
        end
    end

endmodule

// File: rtl/mag_comp_pipe.sv
// Registered magnitude comparator with valid/ready handshakes and saturating outcome counters.
module mag_comp_pipe
    import comp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic [WIDTH-1:0] max_o,
    output logic [WIDTH-1:0] min_o,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             state;
    logic             state_next;
    logic             accept;
    cmp_res_t         core_res;
    logic [WIDTH-1:0] core_max;
    logic [WIDTH-1:0] core_min;

    mag_comp_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a          (a),
        .b          (b),
        .signed_mode(signed_mode),
        .res        (core_res),
        .max        (core_max),
        .min        (core_min)
    );

    // A single output register with no skid buffer: the input side can load only
    // when the register is empty or is being drained in the same cycle.
    assign out_valid = (state == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    // Next-state decode for the EMPTY/FULL occupancy tracker.
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (accept) state_next = ST_FULL;
            ST_FULL: begin
                if (accept) begin
                    state_next = ST_FULL;
                end else if (out_ready) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // Occupancy register. Reset discards any pending result.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Result registers load only on accept and otherwise hold, which keeps them stable under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {gt, lt, eq} <= 3'b000;
            max_o        <= '0;
            min_o        <= '0;
        end else if (accept) begin
            {gt, lt, eq} <= core_res;
            max_o        <= core_max;
            min_o        <= core_min;
        end
    end

    // Outcome counters count at acceptance. A clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            gt_cnt <= '0;
            lt_cnt <= '0;
            eq_cnt <= '0;
        end else if (accept) begin
            case (core_res)
                CMP_GT:  gt_cnt <= CNT_W'(sat_inc(cnt_wide_t'(gt_cnt), cnt_wide_t'(CNT_MAX)));
                CMP_LT:  lt_cnt <= CNT_W'(sat_inc(cnt_wide_t'(lt_cnt), cnt_wide_t'(CNT_MAX)));
                default: eq_cnt <= CNT_W'(sat_inc(cnt_wide_t'(eq_cnt), cnt_wide_t'(CNT_MAX)));
            endcase
        end
    end

endmodule

// File: tb/tb_mag_comp_pipe.sv
// Self-checking bench for mag_comp_pipe: directed steps plus a scoreboarded random phase.
module tb_mag_comp_pipe;

    typedef struct {
        logic [2:0] res;
        logic [7:0] mx;
        logic [7:0] mn;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- dut_b: WIDTH=8, CNT_W=16 (scoreboarded) ----------------
    logic       rst_n, in_valid, signed_mode, out_ready, cnt_clr;
    logic [7:0] a, b;
    logic       in_ready, out_valid, gt, lt, eq;
    logic [7:0] max_o, min_o;
    logic [15:0] gt_cnt, lt_cnt, eq_cnt;

    mag_comp_pipe #(.WIDTH(8), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
        .out_ready(out_ready), .gt(gt), .lt(lt), .eq(eq), .max_o(max_o),
        .min_o(min_o), .cnt_clr(cnt_clr), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt),
        .eq_cnt(eq_cnt)
    );

    // ------------- shared 2-bit stimulus for dut_a and dut_c -------------
    logic       w2_rst_n, w2_valid, w2_signed, w2_out_ready, w2_cnt_clr;
    logic [1:0] w2_a, w2_b;

    // dut_a: WIDTH=2, CNT_W=16
    logic        p_in_ready, p_out_valid, p_gt, p_lt, p_eq;
    logic [1:0]  p_max, p_min;
    logic [15:0] p_gt_cnt, p_lt_cnt, p_eq_cnt;

    mag_comp_pipe #(.WIDTH(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(w2_rst_n), .in_valid(w2_valid), .in_ready(p_in_ready),
        .a(w2_a), .b(w2_b), .signed_mode(w2_signed), .out_valid(p_out_valid),
        .out_ready(w2_out_ready), .gt(p_gt), .lt(p_lt), .eq(p_eq), .max_o(p_max),
        .min_o(p_min), .cnt_clr(w2_cnt_clr), .gt_cnt(p_gt_cnt), .lt_cnt(p_lt_cnt),
        .eq_cnt(p_eq_cnt)
    );

    // dut_c: WIDTH=2, CNT_W=2
    logic       q_in_ready, q_out_valid, q_gt, q_lt, q_eq;
    logic [1:0] q_max, q_min;
    logic [1:0] q_gt_cnt, q_lt_cnt, q_eq_cnt;

    mag_comp_pipe #(.WIDTH(2), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(w2_rst_n), .in_valid(w2_valid), .in_ready(q_in_ready),
        .a(w2_a), .b(w2_b), .signed_mode(w2_signed), .out_valid(q_out_valid),
        .out_ready(w2_out_ready), .gt(q_gt), .lt(q_lt), .eq(q_eq), .max_o(q_max),
        .min_o(q_min), .cnt_clr(w2_cnt_clr), .gt_cnt(q_gt_cnt), .lt_cnt(q_lt_cnt),
        .eq_cnt(q_eq_cnt)
    );

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference outcome from integer arithmetic on w-bit operands.
    function automatic logic [2:0] ref_res(input logic [7:0] x, input logic [7:0] y,
                                           input logic s, input int w);
        int vx, vy;
        vx = int'(x);
        vy = int'(y);
        if (s && x[w-1]) vx = vx - (1 << w);
        if (s && y[w-1]) vy = vy - (1 << w);
        if (vx > vy) return 3'b100;
        if (vx < vy) return 3'b010;
        return 3'b001;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard and counter model for dut_b ----------------
    exp_t sb_q[$];
    int   m_gt = 0, m_lt = 0, m_eq = 0, m_acc = 0;

    always @(negedge clk) begin
        exp_t e, got;
        if (!rst_n) begin
            sb_q.delete();
            m_gt = 0; m_lt = 0; m_eq = 0; m_acc = 0;
        end else begin
            check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (out_valid) check("onehot", 64'($countones({gt, lt, eq})), 64'd1);
            if (out_valid && out_ready) begin
                check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    got.res = {gt, lt, eq};
                    check("sb_res", 64'(got.res), 64'(e.res));
                    check("sb_max", 64'(max_o), 64'(e.mx));
                    check("sb_min", 64'(min_o), 64'(e.mn));
                end
            end
            if (in_valid && in_ready) begin
                e.res = ref_res(a, b, signed_mode, 8);
                e.mx  = (e.res == 3'b010) ? b : a;
                e.mn  = (e.res == 3'b010) ? a : b;
                sb_q.push_back(e);
            end
            if (cnt_clr) begin
                m_gt = 0; m_lt = 0; m_eq = 0; m_acc = 0;
            end else if (in_valid && in_ready) begin
                m_acc++;
                case (ref_res(a, b, signed_mode, 8))
                    3'b100:  if (m_gt < 65535) m_gt++;
                    3'b010:  if (m_lt < 65535) m_lt++;
                    default: if (m_eq < 65535) m_eq++;
                endcase
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [2:0] er;
        int         k;

        rst_n = 1'b0; in_valid = 1'b0; signed_mode = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        a = '0; b = '0;
        w2_rst_n = 1'b0; w2_valid = 1'b0; w2_signed = 1'b0; w2_out_ready = 1'b0;
        w2_cnt_clr = 1'b0; w2_a = '0; w2_b = '0;
        cycle();
        cycle();

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_flags", 64'({gt, lt, eq}), 64'd0);
        check("rst_max", 64'(max_o), 64'd0);
        check("rst_min", 64'(min_o), 64'd0);
        check("rst_cnts", 64'({gt_cnt, lt_cnt, eq_cnt}), 64'd0);
        rst_n = 1'b1;
        w2_rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // 1. WIDTH=2 unsigned sweep at full throughput
        w2_out_ready = 1'b1;
        w2_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w2_a = 2'(i);
            w2_b = 2'(i >> 2);
            er = ref_res({6'b0, w2_a}, {6'b0, w2_b}, 1'b0, 2);
            cycle();
            check("sweep_valid", 64'(p_out_valid), 64'd1);
            check("sweep_res", 64'({p_gt, p_lt, p_eq}), 64'(er));
            check("sweep_max", 64'(p_max), 64'((er == 3'b010) ? w2_b : w2_a));
            check("sweep_min", 64'(p_min), 64'((er == 3'b010) ? w2_a : w2_b));
        end
        w2_valid = 1'b0;
        cycle();
        check("sweep_drain", 64'(p_out_valid), 64'd0);
        check("sweep_gt_cnt", 64'(p_gt_cnt), 64'd6);
        check("sweep_lt_cnt", 64'(p_lt_cnt), 64'd6);
        check("sweep_eq_cnt", 64'(p_eq_cnt), 64'd4);

        // 4. CNT_W=2 saturation and clear priority
        w2_cnt_clr = 1'b1;
        cycle();
        w2_cnt_clr = 1'b0;
        check("c_clr", 64'({q_gt_cnt, q_lt_cnt, q_eq_cnt}), 64'd0);
        w2_valid = 1'b1; w2_a = 2'd1; w2_b = 2'd1;
        for (int i = 1; i <= 5; i++) begin
            cycle();
            k = (i > 3) ? 3 : i;
            check("c_eq_sat", 64'(q_eq_cnt), 64'(k));
        end
        w2_cnt_clr = 1'b1; w2_a = 2'd2; w2_b = 2'd1;
        cycle();
        w2_cnt_clr = 1'b0;
        check("c_clr_res", 64'({q_gt, q_lt, q_eq}), 64'b100);
        check("c_clr_win", 64'({q_gt_cnt, q_lt_cnt, q_eq_cnt}), 64'd0);
        w2_signed = 1'b1; w2_a = 2'b10; w2_b = 2'b01;
        cycle();
        check("c_signed_res", 64'({q_gt, q_lt, q_eq}), 64'b010);
        check("c_signed_max", 64'(q_max), 64'b01);
        check("c_signed_min", 64'(q_min), 64'b10);
        w2_valid = 1'b0;
        cycle();

        // 2. Signed vs unsigned on the same operands
        out_ready = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'h01; signed_mode = 1'b1;
        cycle();
        check("s_res", 64'({gt, lt, eq}), 64'b010);
        check("s_max", 64'(max_o), 64'h01);
        check("s_min", 64'(min_o), 64'hFF);
        signed_mode = 1'b0;
        cycle();
        check("u_res", 64'({gt, lt, eq}), 64'b100);
        check("u_max", 64'(max_o), 64'hFF);
        check("u_min", 64'(min_o), 64'h01);
        in_valid = 1'b0;
        cycle();

        // 3. Backpressure
        out_ready = 1'b0; in_valid = 1'b1; a = 8'd10; b = 8'd20;
        cycle();
        check("bp_first_valid", 64'(out_valid), 64'd1);
        a = 8'd30; b = 8'd5;
        #1;
        check("bp_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_res", 64'({gt, lt, eq}), 64'b010);
            check("bp_hold_max", 64'(max_o), 64'd20);
            check("bp_hold_min", 64'(min_o), 64'd10);
            check("bp_hold_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        cycle();
        check("bp_next_res", 64'({gt, lt, eq}), 64'b100);
        check("bp_next_max", 64'(max_o), 64'd30);
        check("bp_next_min", 64'(min_o), 64'd5);
        in_valid = 1'b0;
        cycle();
        check("bp_empty", 64'(out_valid), 64'd0);

        // 5. Reset while FULL under backpressure
        out_ready = 1'b0; in_valid = 1'b1; a = 8'd7; b = 8'd7;
        cycle();
        check("rf_full", 64'(out_valid), 64'd1);
        rst_n = 1'b0; in_valid = 1'b0;
        cycle();
        rst_n = 1'b1;
        #1;
        check("rf_out_valid", 64'(out_valid), 64'd0);
        check("rf_cnts", 64'({gt_cnt, lt_cnt, eq_cnt}), 64'd0);
        check("rf_in_ready", 64'(in_ready), 64'd1);

        // 6. Random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            in_valid    = 1'($urandom_range(0, 1));
            out_ready   = 1'($urandom_range(0, 1));
            signed_mode = 1'($urandom_range(0, 1));
            cnt_clr     = ($urandom_range(0, 63) == 0);
            a           = 8'($urandom);
            b           = ($urandom_range(0, 7) == 0) ? a : 8'($urandom);
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        cycle();
        cycle();
        cycle();
        check("rnd_drained", 64'(sb_q.size()), 64'd0);
        check("rnd_out_valid", 64'(out_valid), 64'd0);
        check("rnd_gt_cnt", 64'(gt_cnt), 64'(m_gt));
        check("rnd_lt_cnt", 64'(lt_cnt), 64'(m_lt));
        check("rnd_eq_cnt", 64'(eq_cnt), 64'(m_eq));
        check("rnd_cnt_sum", 64'(int'(gt_cnt) + int'(lt_cnt) + int'(eq_cnt)), 64'(m_acc));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
